acc_responder: RTL and testbench
================================

# acc_responder

Accelerator-side endpoint of the CVA6 accelerator request/response interface. Accepts committed requests (instruction, rs1, rs2, trans_id, store_pending), buffers them in a FIFO and classifies them as vector load, vector store, other or illegal. Issues legal requests to the accelerator backend, tracks outstanding operations and returns one response per request, flagging load/store completion so the core-side pending-memory counters drain. Sits between the core's accelerator port and the Ara dispatch logic.

## Interface
- `XLEN`, 64, operand/result width.
- `TRANS_ID_BITS`, 3, transaction ID width.
- `DEPTH`, 4, request FIFO entries (power of two, ≥2).
- `MAX_OUTSTANDING`, 8, maximum issued-but-uncompleted backend operations.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `acc_req_valid_i`  in  1  request valid.
- `acc_req_ready_o`  out  1  request accepted.
- `acc_req_insn_i`  in  32  instruction word.
- `acc_req_rs1_i`, `acc_req_rs2_i`  in  XLEN  scalar operands.
- `acc_req_trans_id_i`  in  TRANS_ID_BITS  scoreboard ID.
- `acc_req_store_pending_i`  in  1  scalar stores still in flight (live, may drop while valid held).
- `be_valid_o` / `be_ready_i`  out/in  1  backend issue handshake.
- `be_insn_o` 32, `be_rs1_o`/`be_rs2_o` XLEN, `be_trans_id_o` TRANS_ID_BITS, `be_is_load_o`/`be_is_store_o` 1  out  issued request.
- `be_done_valid_i` / `be_done_ready_o`  in/out  1  backend completion handshake.
- `be_done_trans_id_i` TRANS_ID_BITS, `be_done_result_i` XLEN, `be_done_error_i` 1, `be_done_is_load_i`/`be_done_is_store_i` 1  in  completion data.
- `acc_resp_valid_o` / `acc_resp_ready_i`  out/in  1  response handshake.
- `acc_resp_trans_id_o` TRANS_ID_BITS, `acc_resp_result_o` XLEN, `acc_resp_error_o` 1, `acc_resp_load_complete_o`/`acc_resp_store_complete_o` 1  out  response.

## Operation
- Classification on `insn[6:0]`: 0000111 load, 0100111 store, 1010111 other; any other opcode illegal.
- Acceptance: `acc_req_ready_o` = FIFO not full AND NOT (load AND `acc_req_store_pending_i`). Loads are held off until scalar stores drain; stores/others ignore store_pending.
- FIFO stores insn, rs1, rs2, trans_id, class. Push on req handshake, pop on issue handshake or illegal retire.
- Issue: head legal AND outstanding < MAX_OUTSTANDING → `be_valid_o`=1 with head fields. Held stable until `be_ready_i`.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1): +1 on issue handshake, −1 on done handshake, unchanged on both; never wraps.
- Response slot, states EMPTY/FULL. `be_done_ready_o` = EMPTY OR `acc_resp_ready_i`. Done handshake loads slot: trans_id, result, error, load_complete=is_load, store_complete=is_store.
- Illegal head: retired into slot only when slot free and no done handshake that cycle (backend has priority). Response: result 0, error 1, both complete flags 0; never issued.
- FULL→EMPTY on resp handshake with no refill; FULL stays FULL on simultaneous handshake and refill (back-to-back).
- Complete flags only meaningful with `acc_resp_valid_o`=1; exactly one response per accepted request.

## Timing
- Reset: FIFO empty, counter 0, slot EMPTY; `acc_resp_valid_o`, `be_valid_o`, all complete flags, `acc_resp_error_o` = 0; `acc_req_ready_o`=1 for non-loads after reset. `be_done_ready_o`=1. Reset mid-operation discards all queued/outstanding state without responses.
- Request accepted in cycle T → `be_valid_o` earliest T+1 (no fall-through).
- Done handshake in T → `acc_resp_valid_o` in T+1. Illegal at head in T → response T+1.
- Full FIFO: ready low; pop and push in same cycle allowed only when not full (ready not combinationally dependent on pop).
- Counter at MAX_OUTSTANDING: `be_valid_o` low; done handshake in T re-enables issue in T+1.

## Configuration
- `ACC_RESPONDER_ILLEGAL_CHECK_EN`: defined → illegal-opcode detection and error responses as above. Undefined → every opcode treated as legal (class "other" unless load/store), all entries issued to backend, `acc_resp_error_o` driven only by `be_done_error_i`.

## Test plan
- Single OP-V request (insn 0x0200_0057, trans_id 3) accepted T0 → `be_valid_o` T1; done T3 result 0x55 → resp T4: trans_id 3, result 0x55, error 0, flags 0.
- Load (insn 0x0200_0007) with store_pending=1 for 5 cycles → ready 0 for 5 cycles, accepted cycle after drop; response carries load_complete=1.
- Illegal insn 0x0000_0013, trans_id 5 (macro defined) → no backend issue, resp error 1, result 0; macro undefined → issued to backend.
- Fill FIFO with 4 stores, `be_ready_i`=0 → 5th request ready 0; release → all issue in order, 4 responses with store_complete=1.
- MAX_OUTSTANDING=8 reached, backend withholds done → `be_valid_o` low; one done → issue resumes next cycle.
- `acc_resp_ready_i`=0 while done pending → `be_done_ready_o`=0, slot holds; reset asserted mid-stream → all valids 0 next cycle, counter 0.

Source files
------------

// File: rtl/acc_responder.sv
// ============================================================================
// Module   : acc_responder
// Brief    : Accelerator-side endpoint of the core accelerator request/response
//            port. Optional macro ACC_RESPONDER_ILLEGAL_CHECK_EN enables
//            illegal-opcode detection with error responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_responder #(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned TRANS_ID_BITS   = 3,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     acc_req_valid_i,
  output logic                     acc_req_ready_o,
  input  logic [31:0]              acc_req_insn_i,
  input  logic [XLEN-1:0]          acc_req_rs1_i,
  input  logic [XLEN-1:0]          acc_req_rs2_i,
  input  logic [TRANS_ID_BITS-1:0] acc_req_trans_id_i,
  input  logic                     acc_req_store_pending_i,
  output logic                     be_valid_o,
  input  logic                     be_ready_i,
  output logic [31:0]              be_insn_o,
  output logic [XLEN-1:0]          be_rs1_o,
  output logic [XLEN-1:0]          be_rs2_o,
  output logic [TRANS_ID_BITS-1:0] be_trans_id_o,
  output logic                     be_is_load_o,
  output logic                     be_is_store_o,
  input  logic                     be_done_valid_i,
  output logic                     be_done_ready_o,
  input  logic [TRANS_ID_BITS-1:0] be_done_trans_id_i,
  input  logic [XLEN-1:0]          be_done_result_i,
  input  logic                     be_done_error_i,
  input  logic                     be_done_is_load_i,
  input  logic                     be_done_is_store_i,
  output logic                     acc_resp_valid_o,
  input  logic                     acc_resp_ready_i,
  output logic [TRANS_ID_BITS-1:0] acc_resp_trans_id_o,
  output logic [XLEN-1:0]          acc_resp_result_o,
  output logic                     acc_resp_error_o,
  output logic                     acc_resp_load_complete_o,
  output logic                     acc_resp_store_complete_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {CLS_OTHER, CLS_LOAD, CLS_STORE, CLS_ILLEGAL} cls_e;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

  typedef struct packed {
    logic [31:0]              insn;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
    logic [TRANS_ID_BITS-1:0] tid;
    cls_e                     cls;
  } entry_t;

  function automatic cls_e classify(input logic [6:0] opcode);
    cls_e c;
    case (opcode)
      7'b0000111: c = CLS_LOAD;
      7'b0100111: c = CLS_STORE;
      7'b1010111: c = CLS_OTHER;
`ifdef ACC_RESPONDER_ILLEGAL_CHECK_EN
      default:    c = CLS_ILLEGAL;
`else
      default:    c = CLS_OTHER;
`endif
    endcase
    return c;
  endfunction

  entry_t                   mem_q [DEPTH];
  entry_t                   mem_d [DEPTH];
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [OW-1:0]            outst_q, outst_d;
  slot_e                    slot_q, slot_d;
  logic [TRANS_ID_BITS-1:0] resp_tid_q, resp_tid_d;
  logic [XLEN-1:0]          resp_result_q, resp_result_d;
  logic                     resp_err_q, resp_err_d;
  logic                     resp_ld_q, resp_ld_d;
  logic                     resp_st_q, resp_st_d;

  entry_t req_entry, head;
  logic   fifo_empty, fifo_full, push, pop, issue_hs, done_hs, retire, head_illegal;

  assign req_entry = '{insn: acc_req_insn_i, rs1: acc_req_rs1_i, rs2: acc_req_rs2_i,
                       tid: acc_req_trans_id_i, cls: classify(acc_req_insn_i[6:0])};
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));

  // Loads wait for scalar stores to drain; ready never looks at this cycle's pop.
  assign acc_req_ready_o = !fifo_full &&
                           !((req_entry.cls == CLS_LOAD) && acc_req_store_pending_i);
  assign push = acc_req_valid_i && acc_req_ready_o;

  assign head_illegal  = !fifo_empty && (head.cls == CLS_ILLEGAL);
  assign be_valid_o    = !fifo_empty && (head.cls != CLS_ILLEGAL) &&
                         (outst_q < OW'(MAX_OUTSTANDING));
  assign be_insn_o     = head.insn;
  assign be_rs1_o      = head.rs1;
  assign be_rs2_o      = head.rs2;
  assign be_trans_id_o = head.tid;
  assign be_is_load_o  = (head.cls == CLS_LOAD);
  assign be_is_store_o = (head.cls == CLS_STORE);
  assign issue_hs      = be_valid_o && be_ready_i;

  assign be_done_ready_o = (slot_q == SLOT_EMPTY) || acc_resp_ready_i;
  assign done_hs         = be_done_valid_i && be_done_ready_o;
  // Backend completions win the slot over illegal retirement.
  assign retire          = head_illegal && be_done_ready_o && !done_hs;
  assign pop             = issue_hs || retire;

  assign acc_resp_valid_o          = (slot_q == SLOT_FULL);
  assign acc_resp_trans_id_o       = resp_tid_q;
  assign acc_resp_result_o         = resp_result_q;
  assign acc_resp_error_o          = resp_err_q;
  assign acc_resp_load_complete_o  = resp_ld_q;
  assign acc_resp_store_complete_o = resp_st_q;

  always_comb begin
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outst_d       = outst_q;
    slot_d        = slot_q;
    resp_tid_d    = resp_tid_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
    resp_ld_d     = resp_ld_q;
    resp_st_d     = resp_st_q;

    if (push) begin
      mem_d[wr_ptr_q] = req_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase

    case ({issue_hs, done_hs})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   if (outst_q != '0) outst_d = outst_q - OW'(1);
      default: ;
    endcase

    if (done_hs) begin
      slot_d        = SLOT_FULL;
      resp_tid_d    = be_done_trans_id_i;
      resp_result_d = be_done_result_i;
      resp_err_d    = be_done_error_i;
      resp_ld_d     = be_done_is_load_i;
      resp_st_d     = be_done_is_store_i;
    end else if (retire) begin
      slot_d        = SLOT_FULL;
      resp_tid_d    = head.tid;
      resp_result_d = '0;
      resp_err_d    = 1'b1;
      resp_ld_d     = 1'b0;
      resp_st_d     = 1'b0;
    end else if (acc_resp_ready_i) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outst_q       <= '0;
      slot_q        <= SLOT_EMPTY;
      resp_tid_q    <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      resp_ld_q     <= 1'b0;
      resp_st_q     <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outst_q       <= outst_d;
      slot_q        <= slot_d;
      resp_tid_q    <= resp_tid_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
      resp_ld_q     <= resp_ld_d;
      resp_st_q     <= resp_st_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_responder.sv
// ============================================================================
// Module   : tb_acc_responder
// Brief    : Directed plus randomized bench for acc_responder, checked against a
//            queue-based transaction model of the request/response endpoint.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_responder;

  localparam int XLEN  = 64;
  localparam int TIDW  = 3;
  localparam int DEPTH = 4;
  localparam int MAXO  = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            acc_req_valid_i, acc_req_ready_o, acc_req_store_pending_i;
  logic [31:0]     acc_req_insn_i;
  logic [XLEN-1:0] acc_req_rs1_i, acc_req_rs2_i;
  logic [TIDW-1:0] acc_req_trans_id_i;
  logic            be_valid_o, be_ready_i, be_is_load_o, be_is_store_o;
  logic [31:0]     be_insn_o;
  logic [XLEN-1:0] be_rs1_o, be_rs2_o;
  logic [TIDW-1:0] be_trans_id_o;
  logic            be_done_valid_i, be_done_ready_o, be_done_error_i;
  logic            be_done_is_load_i, be_done_is_store_i;
  logic [TIDW-1:0] be_done_trans_id_i;
  logic [XLEN-1:0] be_done_result_i;
  logic            acc_resp_valid_o, acc_resp_ready_i, acc_resp_error_o;
  logic            acc_resp_load_complete_o, acc_resp_store_complete_o;
  logic [TIDW-1:0] acc_resp_trans_id_o;
  logic [XLEN-1:0] acc_resp_result_o;

  always #5 clk_i = ~clk_i;

  acc_responder #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .acc_req_valid_i(acc_req_valid_i), .acc_req_ready_o(acc_req_ready_o),
    .acc_req_insn_i(acc_req_insn_i), .acc_req_rs1_i(acc_req_rs1_i), .acc_req_rs2_i(acc_req_rs2_i),
    .acc_req_trans_id_i(acc_req_trans_id_i), .acc_req_store_pending_i(acc_req_store_pending_i),
    .be_valid_o(be_valid_o), .be_ready_i(be_ready_i), .be_insn_o(be_insn_o),
    .be_rs1_o(be_rs1_o), .be_rs2_o(be_rs2_o), .be_trans_id_o(be_trans_id_o),
    .be_is_load_o(be_is_load_o), .be_is_store_o(be_is_store_o),
    .be_done_valid_i(be_done_valid_i), .be_done_ready_o(be_done_ready_o),
    .be_done_trans_id_i(be_done_trans_id_i), .be_done_result_i(be_done_result_i),
    .be_done_error_i(be_done_error_i), .be_done_is_load_i(be_done_is_load_i),
    .be_done_is_store_i(be_done_is_store_i),
    .acc_resp_valid_o(acc_resp_valid_o), .acc_resp_ready_i(acc_resp_ready_i),
    .acc_resp_trans_id_o(acc_resp_trans_id_o), .acc_resp_result_o(acc_resp_result_o),
    .acc_resp_error_o(acc_resp_error_o), .acc_resp_load_complete_o(acc_resp_load_complete_o),
    .acc_resp_store_complete_o(acc_resp_store_complete_o)
  );

  typedef struct {
    logic [31:0]     insn;
    logic [XLEN-1:0] rs1, rs2;
    logic [TIDW-1:0] tid;
    bit              ld, st, ill;
  } req_t;

  typedef struct {
    logic [TIDW-1:0] tid;
    logic [XLEN-1:0] res;
    bit              err, ld, st;
  } rsp_t;

  req_t pend[$];      // accepted, still queued inside the endpoint
  req_t outs[$];      // issued to the backend, not yet completed
  bit   slot_full;
  rsp_t slot;
  bit   last_req_hs;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic req_t decode(input logic [31:0] insn, input logic [XLEN-1:0] rs1,
                                  input logic [XLEN-1:0] rs2, input logic [TIDW-1:0] tid);
    req_t r;
    r.insn = insn; r.rs1 = rs1; r.rs2 = rs2; r.tid = tid;
    r.ld = (insn[6:0] == 7'h07);
    r.st = (insn[6:0] == 7'h27);
`ifdef ACC_RESPONDER_ILLEGAL_CHECK_EN
    r.ill = !(r.ld || r.st || insn[6:0] == 7'h57);
`else
    r.ill = 1'b0;
`endif
    return r;
  endfunction

  // Evaluated at the falling edge: check outputs, then advance the model by the
  // handshakes that the coming rising edge will take.
  task automatic model_eval();
    req_t in_r;
    bit exp_rdy, exp_bev, exp_dr, iss, dhs, ret;
    in_r = decode(acc_req_insn_i, acc_req_rs1_i, acc_req_rs2_i, acc_req_trans_id_i);
    last_req_hs = 1'b0;
    if (rst_i) begin
      pend.delete(); outs.delete(); slot_full = 1'b0;
      return;
    end
    exp_rdy = (pend.size() < DEPTH) && !(in_r.ld && acc_req_store_pending_i);
    chk("req_ready", acc_req_ready_o, exp_rdy);
    exp_bev = (pend.size() > 0) && !pend[0].ill && (outs.size() < MAXO);
    chk("be_valid", be_valid_o, exp_bev);
    if (exp_bev) begin
      chk("be_insn", be_insn_o, pend[0].insn);
      chk("be_rs1", be_rs1_o, pend[0].rs1);
      chk("be_rs2", be_rs2_o, pend[0].rs2);
      chk("be_tid", be_trans_id_o, pend[0].tid);
      chk("be_ld_st", {be_is_load_o, be_is_store_o}, {pend[0].ld, pend[0].st});
    end
    exp_dr = !slot_full || acc_resp_ready_i;
    chk("done_ready", be_done_ready_o, exp_dr);
    chk("resp_valid", acc_resp_valid_o, slot_full);
    if (slot_full) begin
      chk("resp_tid", acc_resp_trans_id_o, slot.tid);
      chk("resp_result", acc_resp_result_o, slot.res);
      chk("resp_err_flags", {acc_resp_error_o, acc_resp_load_complete_o, acc_resp_store_complete_o},
          {slot.err, slot.ld, slot.st});
    end
    last_req_hs = acc_req_valid_i && exp_rdy;
    iss = exp_bev && be_ready_i;
    dhs = be_done_valid_i && exp_dr;
    ret = (pend.size() > 0) && pend[0].ill && exp_dr && !dhs;
    if (dhs) begin
      slot_full = 1'b1;
      slot = '{tid: be_done_trans_id_i, res: be_done_result_i, err: be_done_error_i,
               ld: be_done_is_load_i, st: be_done_is_store_i};
      for (int i = 0; i < outs.size(); i++)
        if (outs[i].tid == be_done_trans_id_i) begin outs.delete(i); break; end
    end else if (ret) begin
      slot_full = 1'b1;
      slot = '{tid: pend[0].tid, res: '0, err: 1'b1, ld: 1'b0, st: 1'b0};
    end else if (acc_resp_ready_i) begin
      slot_full = 1'b0;
    end
    if (iss) outs.push_back(pend[0]);
    if (iss || ret) void'(pend.pop_front());
    if (last_req_hs) pend.push_back(in_r);
  endtask

  task automatic step();
    @(negedge clk_i);
    model_eval();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [31:0] insn, input logic [TIDW-1:0] tid);
    acc_req_valid_i = v; acc_req_insn_i = insn; acc_req_trans_id_i = tid;
    acc_req_rs1_i = {$urandom, $urandom}; acc_req_rs2_i = {$urandom, $urandom};
  endtask

  task automatic set_done(input bit v, input logic [TIDW-1:0] tid, input logic [XLEN-1:0] res,
                          input bit err, input bit ld, input bit st);
    be_done_valid_i = v; be_done_trans_id_i = tid; be_done_result_i = res;
    be_done_error_i = err; be_done_is_load_i = ld; be_done_is_store_i = st;
  endtask

  task automatic rand_done();
    int k;
    if (outs.size() > 0 && ($urandom % 2) == 1) begin
      k = $urandom_range(0, outs.size() - 1);
      set_done(1'b1, outs[k].tid, outs[k].rs1 ^ outs[k].rs2, ($urandom % 8) == 0,
               outs[k].ld, outs[k].st);
    end else begin
      set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int n_acc;
    logic [31:0] w;
    rst_i = 1'b1; acc_req_store_pending_i = 1'b0; be_ready_i = 1'b0; acc_resp_ready_i = 1'b0;
    set_req(1'b0, 32'h0200_0057, '0);
    set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(); step();
    rst_i = 1'b0;
    #1;
    chk("rst_resp_valid", acc_resp_valid_o, 1'b0);
    chk("rst_be_valid", be_valid_o, 1'b0);
    chk("rst_err_flags", {acc_resp_error_o, acc_resp_load_complete_o, acc_resp_store_complete_o}, 3'b000);
    chk("rst_done_ready", be_done_ready_o, 1'b1);
    chk("rst_req_ready", acc_req_ready_o, 1'b1);

    // Single OP-V request: issue one cycle after accept, response one after done.
    set_req(1'b1, 32'h0200_0057, 3'd3);
    #1; chk("opv_no_fallthrough", be_valid_o, 1'b0);
    step();
    set_req(1'b0, 32'h0200_0057, '0);
    chk("opv_issue", be_valid_o, 1'b1);
    chk("opv_issue_tid", be_trans_id_o, 3'd3);
    step();
    be_ready_i = 1'b1; step(); be_ready_i = 1'b0;
    set_done(1'b1, 3'd3, 64'h55, 1'b0, 1'b0, 1'b0);
    step();
    set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("opv_resp_valid", acc_resp_valid_o, 1'b1);
    chk("opv_resp_tid", acc_resp_trans_id_o, 3'd3);
    chk("opv_resp_result", acc_resp_result_o, 64'h55);
    chk("opv_resp_flags", {acc_resp_error_o, acc_resp_load_complete_o, acc_resp_store_complete_o}, 3'b000);
    acc_resp_ready_i = 1'b1; step(); acc_resp_ready_i = 1'b0;

    // Load held off while scalar stores are pending.
    set_req(1'b1, 32'h0200_0007, 3'd1);
    acc_req_store_pending_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; chk("load_held", acc_req_ready_o, 1'b0);
      step();
    end
    acc_req_store_pending_i = 1'b0;
    #1; chk("load_released", acc_req_ready_o, 1'b1);
    step();
    set_req(1'b0, 32'h0200_0057, '0);
    be_ready_i = 1'b1; step(); be_ready_i = 1'b0;
    set_done(1'b1, 3'd1, 64'h77, 1'b0, 1'b1, 1'b0);
    step();
    set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("load_resp_flags", {acc_resp_load_complete_o, acc_resp_store_complete_o}, 2'b10);
    acc_resp_ready_i = 1'b1; step();

    // Opcode outside the vector space.
    set_req(1'b1, 32'h0000_0013, 3'd5);
    step();
    set_req(1'b0, 32'h0200_0057, '0);
`ifdef ACC_RESPONDER_ILLEGAL_CHECK_EN
    chk("illegal_not_issued", be_valid_o, 1'b0);
    step();
    chk("illegal_resp_valid", acc_resp_valid_o, 1'b1);
    chk("illegal_resp", {acc_resp_trans_id_o, acc_resp_error_o}, {3'd5, 1'b1});
    chk("illegal_result", acc_resp_result_o, 64'h0);
    step();
`else
    chk("nocheck_issued", be_valid_o, 1'b1);
    chk("nocheck_insn", be_insn_o, 32'h0000_0013);
    be_ready_i = 1'b1; step(); be_ready_i = 1'b0;
    set_done(1'b1, 3'd5, 64'h13, 1'b0, 1'b0, 1'b0);
    step();
    set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("nocheck_resp", {acc_resp_valid_o, acc_resp_error_o}, 2'b10);
    step();
`endif
    acc_resp_ready_i = 1'b0;

    // Fill the FIFO with stores while the backend stalls.
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 32'h0200_0027, TIDW'(i));
      #1; chk("fill_ready", acc_req_ready_o, 1'b1);
      step();
    end
    set_req(1'b1, 32'h0200_0027, 3'd4);
    #1; chk("full_ready", acc_req_ready_o, 1'b0);
    step();
    set_req(1'b0, 32'h0200_0057, '0);
    be_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", {be_valid_o, be_trans_id_o}, {1'b1, TIDW'(i)});
      step();
    end
    be_ready_i = 1'b0; acc_resp_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_done(1'b1, TIDW'(i), 64'(i), 1'b0, 1'b0, 1'b1);
      step();
      chk("store_resp", {acc_resp_valid_o, acc_resp_trans_id_o, acc_resp_store_complete_o},
          {1'b1, TIDW'(i), 1'b1});
    end
    set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step();

    // Saturate the outstanding counter.
    be_ready_i = 1'b1; n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      set_req(n_acc < MAXO + 1, 32'h0200_0057, TIDW'(n_acc));
      step();
      if (last_req_hs) n_acc++;
    end
    set_req(1'b0, 32'h0200_0057, '0);
    chk("max_blocked", be_valid_o, 1'b0);
    set_done(1'b1, 3'd0, 64'hAB, 1'b0, 1'b0, 1'b0);
    #1; chk("max_blocked_done_cycle", be_valid_o, 1'b0);
    step();
    set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("max_resumed", be_valid_o, 1'b1);
    acc_resp_ready_i = 1'b0;
    set_done(1'b1, 3'd1, 64'hCD, 1'b0, 1'b0, 1'b0);
    #1; chk("slot_backpressure", be_done_ready_o, 1'b0);
    step(); step();
    chk("slot_hold", {acc_resp_valid_o, acc_resp_trans_id_o, acc_resp_result_o}, {1'b1, 3'd0, 64'hAB});
    rst_i = 1'b1; step(); rst_i = 1'b0;
    set_done(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("midrst_valids", {acc_resp_valid_o, be_valid_o}, 2'b00);

    // Randomized traffic against the model, then a drain phase.
    for (int c = 0; c < 3000; c++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[6:0] = 7'h07;
        1: w[6:0] = 7'h27;
        2: w[6:0] = 7'h57;
        default: w[6:0] = (($urandom % 2) == 1) ? 7'h13 : 7'h33;
      endcase
      set_req(($urandom % 3) != 0, w, TIDW'($urandom));
      acc_req_store_pending_i = ($urandom % 4) == 0;
      be_ready_i = ($urandom % 4) != 0;
      acc_resp_ready_i = ($urandom % 3) != 0;
      rand_done();
      step();
    end
    set_req(1'b0, 32'h0200_0057, '0);
    be_ready_i = 1'b1; acc_resp_ready_i = 1'b1;
    for (int c = 0; c < 300; c++) begin
      rand_done();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
